// File: rtl/rev_counter_ctrl.sv
// rtl/rev_counter_ctrl.sv - prescaled up/down revolution counter with IDLE/RUN/DONE control
module rev_counter_ctrl #(
  parameter int unsigned PRESCALE = 5000000,
  parameter logic [15:0] MAX      = 16'hFFFF
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        start,
  input  logic        stop,
  input  logic        dir,
  input  logic        mode,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] cnt,
  output logic        step,
  output logic        Rc,
  output logic        running,
  output logic        done
);

  localparam int unsigned PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        state_q;
  logic [PW-1:0] presc_q;
  logic [15:0]   cnt_q;
  logic          step_q;
  logic          rc_q;
  logic [15:0]   load_d;
  logic          at_limit_d;

  assign load_d     = (load_val > MAX) ? MAX : load_val;
  assign at_limit_d = dir ? (cnt_q >= MAX) : (cnt_q == 16'd0);

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      cnt_q   <= '0;
      step_q  <= 1'b0;
      rc_q    <= 1'b0;
    end else begin
      step_q <= 1'b0;
      rc_q   <= 1'b0;
      // load > stop > start > tick; an ignored stop/start falls through
      if (load) begin
        cnt_q   <= load_d;
        presc_q <= '0;
        if (state_q == S_DONE) state_q <= S_IDLE;
      end else if (stop && state_q != S_IDLE) begin
        state_q <= S_IDLE;
        presc_q <= '0;
      end else if (start && state_q != S_RUN) begin
        state_q <= S_RUN;
        presc_q <= '0;
      end else if (state_q == S_RUN) begin
        if (presc_q == PS_LAST) begin
          presc_q <= '0;
          if (!at_limit_d) begin
            cnt_q  <= dir ? cnt_q + 16'd1 : cnt_q - 16'd1;
            step_q <= 1'b1;
          end else if (!mode) begin
            cnt_q  <= dir ? 16'd0 : MAX;
            step_q <= 1'b1;
            rc_q   <= 1'b1;
          end else begin
            rc_q    <= 1'b1;
            state_q <= S_DONE;
          end
        end else begin
          presc_q <= presc_q + PW'(1);
        end
      end
    end
  end

  assign cnt     = cnt_q;
  assign step    = step_q;
  assign Rc      = rc_q;
  assign running = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);

endmodule

// File: tb/tb_rev_counter_ctrl.sv
// tb/tb_rev_counter_ctrl.sv - self-checking bench for rev_counter_ctrl (PRESCALE=4, MAX=9)
module tb_rev_counter_ctrl;

  localparam int P  = 4;
  localparam int MX = 9;

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0, stop = 1'b0, dir = 1'b1, mode = 1'b0, load = 1'b0;
  logic [15:0] load_val = 16'd0;
  logic [15:0] cnt;
  logic        step, Rc, running, done;

  rev_counter_ctrl #(.PRESCALE(P), .MAX(16'(MX))) dut (
    .clk(clk), .RST(RST), .start(start), .stop(stop), .dir(dir), .mode(mode),
    .load(load), .load_val(load_val), .cnt(cnt), .step(step), .Rc(Rc),
    .running(running), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit check_en = 1'b0;
  bit prev_step = 1'b0, prev_rc = 1'b0;

  // reference model: 0 = idle, 1 = run, 2 = done; m_el counts cycles since the last (re)start
  int m_st = 0, m_el = 0, m_cnt = 0;
  bit m_step = 1'b0, m_rc = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_st = 0; m_el = 0; m_cnt = 0; m_step = 1'b0; m_rc = 1'b0;
  endtask

  task automatic m_update();
    bit lim;
    m_step = 1'b0;
    m_rc   = 1'b0;
    if (RST) begin
      m_reset();
    end else if (load) begin
      m_cnt = (int'(load_val) > MX) ? MX : int'(load_val);
      m_el  = 0;
      if (m_st == 2) m_st = 0;
    end else if (stop && m_st != 0) begin
      m_st = 0; m_el = 0;
    end else if (start && m_st != 1) begin
      m_st = 1; m_el = 0;
    end else if (m_st == 1) begin
      m_el++;
      if (m_el == P) begin
        m_el = 0;
        lim = dir ? (m_cnt == MX) : (m_cnt == 0);
        if (!lim) begin
          m_cnt  = dir ? m_cnt + 1 : m_cnt - 1;
          m_step = 1'b1;
        end else if (!mode) begin
          m_cnt  = dir ? 0 : MX;
          m_step = 1'b1;
          m_rc   = 1'b1;
        end else begin
          m_rc = 1'b1;
          m_st = 2;
        end
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    m_update();
    @(negedge clk);
    start = 1'b0; stop = 1'b0; load = 1'b0;
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("cnt", int'(cnt), m_cnt);
      chk("step", int'(step), int'(m_step));
      chk("rc", int'(Rc), int'(m_rc));
      chk("running", int'(running), int'(m_st == 1));
      chk("done", int'(done), int'(m_st == 2));
      chk("cnt_range", int'(int'(cnt) <= MX), 1);
      chk("step_pair", int'(step && prev_step), 0);
      chk("rc_pair", int'(Rc && prev_rc), 0);
      prev_step = step;
      prev_rc   = Rc;
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    m_reset();
    check_en = 1'b1;
    chk("rst_cnt", int'(cnt), 0);
    chk("rst_running", int'(running), 0);
    chk("rst_done", int'(done), 0);
    RST = 1'b0;
    repeat (3) cyc();
    chk("idle_cnt", int'(cnt), 0);

    // count up from reset
    dir = 1'b1; mode = 1'b0; start = 1'b1; cyc();
    chk("t35_running", int'(running), 1);
    for (int i = 1; i <= 12; i++) begin
      cyc();
      chk("t35_step", int'(step), int'(i % 4 == 0));
      chk("t35_cnt", int'(cnt), i / 4);
    end
    chk("t35_model", m_cnt, 3);
    stop = 1'b1; cyc();
    chk("t35_stop", int'(running), 0);

    // wrap at MAX
    load_val = 16'd9; load = 1'b1; cyc();
    chk("t36_load", int'(cnt), 9);
    start = 1'b1; cyc();
    repeat (4) cyc();
    chk("t36_cnt", int'(cnt), 0);
    chk("t36_step", int'(step), 1);
    chk("t36_rc", int'(Rc), 1);
    repeat (4) cyc();
    chk("t36_cnt2", int'(cnt), 1);
    stop = 1'b1; cyc();

    // halt at zero going down
    load_val = 16'd0; load = 1'b1; cyc();
    dir = 1'b0; mode = 1'b1; start = 1'b1; cyc();
    repeat (4) cyc();
    chk("t37_rc", int'(Rc), 1);
    chk("t37_step", int'(step), 0);
    chk("t37_cnt", int'(cnt), 0);
    chk("t37_done", int'(done), 1);
    chk("t37_running", int'(running), 0);
    repeat (2) cyc();
    chk("t37_hold", int'(cnt), 0);
    dir = 1'b1; start = 1'b1; cyc();
    repeat (4) cyc();
    chk("t37_cnt2", int'(cnt), 1);
    chk("t37_model", m_cnt, 1);
    mode = 1'b0;

    // stop on the tick cycle
    stop = 1'b1; cyc();
    load_val = 16'd5; load = 1'b1; cyc();
    start = 1'b1; cyc();
    repeat (3) cyc();
    stop = 1'b1; cyc();
    chk("t38_cnt", int'(cnt), 5);
    chk("t38_step", int'(step), 0);
    chk("t38_running", int'(running), 0);
    start = 1'b1; cyc();
    repeat (3) cyc();
    chk("t38_pre", int'(cnt), 5);
    cyc();
    chk("t38_cnt2", int'(cnt), 6);
    chk("t38_step2", int'(step), 1);

    // load on the tick cycle, clamped
    repeat (3) cyc();
    load_val = 16'h00FF; load = 1'b1; cyc();
    chk("t39_cnt", int'(cnt), 9);
    chk("t39_step", int'(step), 0);
    chk("t39_rc", int'(Rc), 0);
    chk("t39_running", int'(running), 1);
    repeat (3) cyc();
    chk("t39_wait", int'(step), 0);
    cyc();
    chk("t39_cnt2", int'(cnt), 0);
    chk("t39_step2", int'(step), 1);
    chk("t39_model", m_cnt, 0);

    // asynchronous reset between edges
    repeat (2) cyc();
    #2 RST = 1'b1;
    m_reset();
    #1;
    chk("t40_cnt", int'(cnt), 0);
    chk("t40_step", int'(step), 0);
    chk("t40_rc", int'(Rc), 0);
    chk("t40_running", int'(running), 0);
    chk("t40_done", int'(done), 0);
    @(negedge clk);
    cyc();
    RST = 1'b0;
    repeat (6) cyc();
    chk("t40_idle", int'(running), 0);
    start = 1'b1; cyc();
    repeat (4) cyc();
    chk("t40_resume", int'(cnt), 1);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 4) begin
        load = 1'b1;
        load_val = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, MX));
      end else if (r < 8) begin
        stop = 1'b1;
      end else if (r < 16) begin
        start = 1'b1;
      end
      if ($urandom_range(0, 7) == 0) dir = ~dir;
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      cyc();
    end

    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
